// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner
// Purpose  : Time-multiplexed digit scanner for an N-digit 7-segment display.
//            Latches a packed hex value, walks its digits one refresh slot at
//            a time, feeds the current nibble to a hex-to-segment decoder and
//            drives one anode enable per digit. Each slot opens with a short
//            dead time (all anodes off) to prevent ghosting. A new value is
//            only shown from the next frame boundary, so a frame never tears.
// Ports    : clk          - clock, all logic on the rising edge
//            rst          - synchronous active-high reset
//            value_in     - packed hex digits, [3:0] = digit 0
//            load         - capture value_in this cycle
//            digit_out    - nibble for the decoder
//            digit_blank  - 1 when no anode is active
//            anode        - per-digit enables, polarity set by ANODE_ACTIVE_LOW
//            frame_start  - 1-cycle pulse when the display register updates
// Options  : define LEADING_ZERO_BLANK_EN to suppress leading zero digits
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int BLANK_CYCLES     = 2,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic                      load,
    output logic [3:0]                digit_out,
    output logic                      digit_blank,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic                      frame_start
);

    localparam int c_VAL_W = 4 * NUM_DIGITS;
    localparam int c_CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK   = c_CNT_W'(BLANK_CYCLES);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_ANODE_OFF =
        (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // ------------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------------
    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_err_digits
            $error("seven_segment_scanner: NUM_DIGITS must be 1..8");
        end
        if (REFRESH_DIV < 2) begin : g_err_div
            $error("seven_segment_scanner: REFRESH_DIV must be >= 2");
        end
        if (BLANK_CYCLES < 0 || BLANK_CYCLES > REFRESH_DIV - 1) begin : g_err_blank
            $error("seven_segment_scanner: BLANK_CYCLES must be 0..REFRESH_DIV-1");
        end
    endgenerate

    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_VAL_W-1:0]    r_pending;
    logic [c_VAL_W-1:0]    r_display;

    logic                  w_cnt_wrap;
    logic                  w_frame_wrap;
    logic                  w_in_dead;
    logic                  w_show;
    logic [3:0]            w_digit;
    logic [NUM_DIGITS-1:0] w_onehot;

    assign w_cnt_wrap   = (r_cnt == c_CNT_MAX);
    assign w_frame_wrap = w_cnt_wrap && (r_idx == c_IDX_MAX);
    assign w_digit      = r_display[{r_idx, 2'b00} +: 4];
    assign w_onehot     = NUM_DIGITS'(1) << r_idx;

    // With no dead time the comparison against zero would be constant.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_dead
            assign w_in_dead = 1'b0;
        end else begin : g_dead
            assign w_in_dead = (r_cnt < c_BLANK);
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k>0 is hidden when it and every more significant digit are zero.
    // Derived from the display register, so the decision holds for a frame.
    logic [NUM_DIGITS-1:0] w_suppress;

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lzb
            if (k == 0) begin : g_lsd
                assign w_suppress[k] = 1'b0;
            end else begin : g_upper
                assign w_suppress[k] = (r_display[c_VAL_W-1:4*k] == '0);
            end
        end
    endgenerate

    assign w_show = !w_in_dead && !w_suppress[r_idx];
`else
    assign w_show = !w_in_dead;
`endif

    // ------------------------------------------------------------------------
    // Counters, value registers and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_pending   <= '0;
            r_display   <= '0;
            digit_out   <= 4'h0;
            digit_blank <= 1'b1;
            anode       <= c_ANODE_OFF;
            frame_start <= 1'b0;
        end else begin
            if (load) begin
                r_pending <= value_in;
            end

            if (w_cnt_wrap) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + c_IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            // A load on the boundary edge bypasses pending straight to display.
            if (w_frame_wrap) begin
                r_display <= load ? value_in : r_pending;
            end

            frame_start <= w_frame_wrap;
            digit_out   <= w_digit;
            digit_blank <= !w_show;
            anode       <= w_show ? (w_onehot ^ c_ANODE_OFF) : c_ANODE_OFF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_scanner
// Purpose  : Directed self-checking bench for seven_segment_scanner with
//            NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, ANODE_ACTIVE_LOW=1.
//            One frame is 16 cycles; each slot is 1 blank + 3 lit cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  digit_out;
    logic        digit_blank;
    logic [3:0]  anode;
    logic        frame_start;

    int checks;
    int errors;

    seven_segment_scanner #(
        .NUM_DIGITS       (4),
        .REFRESH_DIV      (4),
        .BLANK_CYCLES     (1),
        .ANODE_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .load        (load),
        .digit_out   (digit_out),
        .digit_blank (digit_blank),
        .anode       (anode),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_anode"}, {12'h0, anode}, 16'h000F);
        chk({tag, "_blank"}, {15'h0, digit_blank}, 16'h0001);
        chk({tag, "_digit"}, {12'h0, digit_out}, 16'h0000);
        chk({tag, "_fstart"}, {15'h0, frame_start}, 16'h0000);
    endtask

    // Runs one 16-cycle frame, starting right after a boundary edge, checking
    // that every slot shows 'val'. Optionally asserts load for one edge.
    task automatic check_frame(input string name, input logic [15:0] val,
                               input bit do_load, input int load_at,
                               input logic [15:0] load_val);
        logic [15:0] sh;
        logic [3:0]  oh;
        logic [3:0]  exp_anode;
        bit          sup;
        int          d;
        int          c;
        for (int i = 0; i < 16; i++) begin
            if (do_load && i == load_at) begin
                load     = 1'b1;
                value_in = load_val;
            end
            step();
            load = 1'b0;
            d  = i / 4;
            c  = i % 4;
            sh = val >> (4 * d);
            oh = 4'b0001 << d;
`ifdef LEADING_ZERO_BLANK_EN
            sup = (d > 0) && (sh == 16'h0000);
`else
            sup = 1'b0;
`endif
            exp_anode = (c >= 1 && !sup) ? ~oh : 4'b1111;
            chk($sformatf("%s_c%0d_anode", name, i), {12'h0, anode}, {12'h0, exp_anode});
            chk($sformatf("%s_c%0d_digit", name, i), {12'h0, digit_out}, {12'h0, sh[3:0]});
            chk($sformatf("%s_c%0d_blank", name, i), {15'h0, digit_blank},
                {15'h0, (exp_anode == 4'b1111)});
            chk($sformatf("%s_c%0d_fstart", name, i), {15'h0, frame_start},
                {15'h0, (i == 15)});
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        load     = 1'b0;
        value_in = 16'h0000;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk_reset_outputs($sformatf("reset%0d", i));
        end
        rst = 1'b0;

        // First frame shows zero; first lit anode two cycles after release
        check_frame("frame0", 16'h0000, 1'b1, 2, 16'h1A3F);
        check_frame("f1a3f", 16'h1A3F, 1'b0, 0, 16'h0000);

        // Load 1111 at frame start, 2222 mid-frame: frame keeps old value
        load     = 1'b1;
        value_in = 16'h1111;
        check_frame("notear", 16'h1A3F, 1'b1, 8, 16'h2222);
        check_frame("f2222", 16'h2222, 1'b0, 0, 16'h0000);

        // Load coincident with the boundary edge bypasses to display
        check_frame("bypass", 16'h2222, 1'b1, 15, 16'h00C0);
        check_frame("f00c0", 16'h00C0, 1'b0, 0, 16'h0000);
        check_frame("f00c0b", 16'h00C0, 1'b1, 3, 16'h0000);
        check_frame("f0000", 16'h0000, 1'b0, 0, 16'h0000);

        // Reset mid-slot of digit 2 with a pending value and a load in the rst cycle
        load     = 1'b1;
        value_in = 16'h1A3F;
        for (int i = 0; i < 9; i++) begin
            step();
            load = 1'b0;
        end
        rst      = 1'b1;
        load     = 1'b1;
        value_in = 16'hFFFF;
        step();
        chk_reset_outputs("midrst");
        rst  = 1'b0;
        load = 1'b0;
        check_frame("restart", 16'h0000, 1'b0, 0, 16'h0000);
        check_frame("restart2", 16'h0000, 1'b0, 0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
